// File: rtl/spart_echo_engine.sv
// spart_echo_engine: drives a SPART over its processor bus. After reset it
// programs the baud divisor (low byte, then high byte). It then echoes every
// received byte back through a small FIFO, optionally converting lowercase
// letters to uppercase. A change of baud select while running re-programs
// the divisor and keeps the queued bytes.
module spart_echo_engine #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [1:0]                   br_cfg,
   input  logic                         mode,
   input  logic                         rda,
   input  logic                         tbr,
   output logic                         iocs,
   output logic                         iorw,
   output logic [1:0]                   ioaddr,
   inout  wire  [7:0]                   databus,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // Divisors are fixed at elaboration using truncating integer division.
   localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ_HZ / (16 * 4800)  - 1);
   localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ_HZ / (16 * 9600)  - 1);
   localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ_HZ / (16 * 19200) - 1);
   localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ_HZ / (16 * 38400) - 1);

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      INIT_LO = 2'b01,
      INIT_HI = 2'b10,
      RUN     = 2'b11
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [1:0]    br_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          ovf_q;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic [15:0]   div_s;
   logic          cfg_chg_s;
   logic          rd_s;
   logic          wr_s;
   logic          drive_s;
   logic [7:0]    wdata_s;
   logic [7:0]    head_s;

   // Uppercase conversion applied to the outgoing byte when enabled.
   function automatic logic [7:0] echo_byte(input logic m, input logic [7:0] b);
      if (m && (b >= 8'h61) && (b <= 8'h7A)) begin
         return b - 8'h20;
      end else begin
         return b;
      end
   endfunction

   assign cfg_chg_s  = (br_cfg != br_q);
   assign head_s     = mem_q[rd_ptr_q];
   assign fifo_count = count_q;
   assign overflow   = ovf_q;
   assign databus    = drive_s ? wdata_s : 8'hzz;

   // Select the divisor for the currently registered baud setting.
   always_comb begin
      div_s = DIV_4800;
      case (br_q)
         2'b00:   div_s = DIV_4800;
         2'b01:   div_s = DIV_9600;
         2'b10:   div_s = DIV_19200;
         2'b11:   div_s = DIV_38400;
         default: div_s = DIV_4800;
      endcase
   end

   // Decode the bus transaction for this cycle; reads win over writes and
   // a baud change seen in RUN suppresses both.
   always_comb begin
      iocs    = 1'b0;
      iorw    = 1'b1;
      ioaddr  = 2'b00;
      drive_s = 1'b0;
      wdata_s = 8'h00;
      rd_s    = 1'b0;
      wr_s    = 1'b0;
      state_d = state_q;
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               state_d = INIT_LO;
            end
            INIT_LO: begin
               iocs    = 1'b1;
               iorw    = 1'b0;
               ioaddr  = 2'b10;
               drive_s = 1'b1;
               wdata_s = div_s[7:0];
               state_d = INIT_HI;
            end
            INIT_HI: begin
               iocs    = 1'b1;
               iorw    = 1'b0;
               ioaddr  = 2'b11;
               drive_s = 1'b1;
               wdata_s = div_s[15:8];
               state_d = RUN;
            end
            RUN: begin
               if (cfg_chg_s) begin
                  state_d = INIT_LO;
               end else if (rda) begin
                  iocs = 1'b1;
                  rd_s = 1'b1;
               end else if (tbr && (count_q != '0)) begin
                  iocs    = 1'b1;
                  iorw    = 1'b0;
                  drive_s = 1'b1;
                  wdata_s = echo_byte(mode, head_s);
                  wr_s    = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = IDLE;
      end
   end

   // State, baud register, FIFO pointers/occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         br_q     <= br_cfg;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         br_q    <= br_cfg;
         if (rd_s) begin
            if (count_q != FULL_COUNT) begin
               wr_ptr_q <= wr_ptr_q + AW'(1);
               count_q  <= count_q + (AW + 1)'(1);
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (wr_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_q - (AW + 1)'(1);
         end else begin
            count_q <= count_q;
         end
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (rst_n && rd_s && (count_q != FULL_COUNT)) begin
         mem_q[wr_ptr_q] <= databus;
      end
   end

endmodule

// File: tb/tb_spart_echo_engine.sv
// Bench for spart_echo_engine: a directed vector table, hand sequences for
// overflow / read priority / baud re-init, then random traffic against a
// queue-based reference model.
module tb_spart_echo_engine;

   localparam int CLK_HZ = 50000000;
   localparam int DEPTH  = 8;

   logic       clk = 1'b0;
   logic       rst_n, mode, rda, tbr;
   logic [1:0] br_cfg;
   logic [7:0] rx_byte;
   logic       iocs, iorw, overflow;
   logic [1:0] ioaddr;
   logic [3:0] fifo_count;
   wire  [7:0] databus;

   always #5 clk = ~clk;

   // The SPART side: returns rx_byte whenever the engine reads.
   assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

   spart_echo_engine #(.CLK_FREQ_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .mode(mode), .rda(rda),
      .tbr(tbr), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: queued bytes, sticky overflow, last seen baud select,
   // and a list of forced cycles (0 = idle, 3 = divisor low, 4 = divisor high).
   logic [7:0] mq[$];
   bit         m_ovf;
   logic [1:0] m_prev;
   int         sched[$];

   // Values sampled in the last step.
   logic       s_iocs, s_iorw;
   logic [1:0] s_addr;
   logic [7:0] s_data;
   int         s_cnt;
   logic       s_ovf;

   typedef struct {
      logic       r;
      logic [1:0] br;
      logic       m, a, t;
      logic [7:0] rx;
      logic       e_cs, e_rw;
      logic [1:0] e_ad;
      logic [7:0] e_d;
      int         e_cnt;
      logic       e_ovf;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int divisor(input logic [1:0] c);
      int baud;
      baud = 4800 << c;
      return (CLK_HZ / (16 * baud) - 1) & 32'h0000FFFF;
   endfunction

   function automatic logic [7:0] echo(input logic [7:0] b, input logic m);
      if (m && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
      return b;
   endfunction

   // One clock cycle: drive inputs, sample and compare with the model,
   // advance through the rising edge, then update the model.
   task automatic step(input logic r, input logic [1:0] br, input logic m,
                       input logic a, input logic t, input logic [7:0] rx);
      int         kind;
      int         dv;
      bit         det;
      logic [7:0] exp_d;
      rst_n = r; br_cfg = br; mode = m; rda = a; tbr = t; rx_byte = rx;
      #3;
      s_iocs = iocs; s_iorw = iorw; s_addr = ioaddr; s_data = databus;
      s_cnt = int'(fifo_count); s_ovf = overflow;
      kind = 0; det = 1'b0; exp_d = 8'h00;
      dv = divisor(m_prev);
      if (!r) kind = 0;
      else if (sched.size() > 0) kind = sched[0];
      else if (br != m_prev) det = 1'b1;
      else if (a) kind = 1;
      else if (t && mq.size() > 0) begin kind = 2; exp_d = echo(mq[0], m); end
      if (kind == 3) exp_d = dv[7:0];
      if (kind == 4) exp_d = dv[15:8];
      chk("iocs", s_iocs, (kind != 0) ? 1 : 0);
      chk("iorw", s_iorw, (kind == 0 || kind == 1) ? 1 : 0);
      chk("ioaddr", s_addr, (kind == 3) ? 2 : (kind == 4) ? 3 : 0);
      if (kind >= 2) chk("wdata", s_data, exp_d);
      if (r) begin
         chk("fifo_count", s_cnt, mq.size());
         chk("overflow", s_ovf, m_ovf);
      end
      @(posedge clk);
      #1;
      if (!r) begin
         mq.delete(); m_ovf = 1'b0; sched.delete();
         sched.push_back(0); sched.push_back(3); sched.push_back(4);
      end else if (sched.size() > 0) begin
         void'(sched.pop_front());
      end else if (det) begin
         sched.push_back(3); sched.push_back(4);
      end else if (kind == 1) begin
         if (mq.size() < DEPTH) mq.push_back(rx);
         else m_ovf = 1'b1;
      end else if (kind == 2) begin
         void'(mq.pop_front());
      end
      m_prev = br;
   endtask

   initial begin
      // r  br    m     a     t     rx     cs    rw    ad     d      cnt ovf
      tbl[0] = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 0, 1'b0};
      tbl[1] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 0, 1'b0};
      tbl[2] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 8'h44, 0, 1'b0};
      tbl[3] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b11, 8'h01, 0, 1'b0};
      tbl[4] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h61, 1'b1, 1'b1, 2'b00, 8'h00, 0, 1'b0};
      tbl[5] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2'b00, 8'h41, 1, 1'b0};
      tbl[6] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 0, 1'b0};

      m_prev = 2'b01; m_ovf = 1'b0;
      #1;
      step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);

      // Directed table: reset, divisor programming, first echo with uppercase.
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].r, tbl[i].br, tbl[i].m, tbl[i].a, tbl[i].t, tbl[i].rx);
         chk($sformatf("tbl%0d_cs", i), s_iocs, tbl[i].e_cs);
         chk($sformatf("tbl%0d_rw", i), s_iorw, tbl[i].e_rw);
         chk($sformatf("tbl%0d_ad", i), s_addr, tbl[i].e_ad);
         if (tbl[i].e_cs && !tbl[i].e_rw) chk($sformatf("tbl%0d_d", i), s_data, tbl[i].e_d);
         if (tbl[i].r) begin
            chk($sformatf("tbl%0d_cnt", i), s_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_ovf", i), s_ovf, tbl[i].e_ovf);
         end
      end

      // Overflow: nine reads with the transmitter blocked.
      for (int i = 0; i < 9; i++) step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
      step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("full_count", s_cnt, 8);
      chk("full_ovf", s_ovf, 1);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
         chk("drain_wr", (s_iocs && !s_iorw) ? 1 : 0, 1);
         chk("drain_order", s_data, 8'h30 + i);
      end
      step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("ninth_absent", s_iocs, 0);
      chk("drained_count", s_cnt, 0);

      // Read priority over a pending write.
      step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'hAA);
      step(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'hBB);
      chk("prio_read", (s_iocs && s_iorw) ? 1 : 0, 1);
      step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("deferred_wr", s_data, 8'hAA);
      step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("second_wr", s_data, 8'hBB);

      // Baud change with three bytes queued.
      step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h11);
      step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h22);
      step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h33);
      step(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 8'h44);
      chk("detect_quiet", s_iocs, 0);
      step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("reinit_lo_ad", s_addr, 2);
      chk("reinit_lo_d", s_data, 8'h50);
      step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("reinit_hi_ad", s_addr, 3);
      chk("reinit_hi_d", s_data, 8'h00);
      step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("resume0", s_data, 8'h11);
      step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("resume1", s_data, 8'h22);
      step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("resume2", s_data, 8'h33);

      // Random traffic, occasional baud changes and mid-operation resets.
      begin
         logic [1:0] br;
         br = 2'b11;
         for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) br = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0, br,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1,
                 8'($urandom_range(8'h50, 8'h80)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
